// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all eight 3-bit input vectors into an external
// 3-input gate, holds each vector for SETTLE_CYCLES+1 cycles, samples the gate
// output on the last hold cycle and compares the captured table to a reference.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       dut_in1,
    output logic       dut_in2,
    output logic       dut_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES);

    state_e     state_q, state_d;
    logic [2:0] idx_q,   idx_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] table_q, table_d;
    logic [7:0] exp_q,   exp_d;
    logic       pass_q,  pass_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic [2:0] vec_q,   vec_d;

    // Next-state logic: sweep sequencing, sampling into the table, and the
    // registered-output values derived from the state being entered.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block from inferring latches.
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        exp_d   = exp_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                // start beats a simultaneous abort; abort alone does nothing here
                if (start) begin
                    exp_d   = expected;
                    table_d = 8'h00;
                    pass_d  = 1'b0;
                    idx_d   = 3'd0;
                    cnt_d   = SETTLE_RELOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    // the sample due this cycle, if any, is discarded
                    pass_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // vector i lands in bit 7-i so vector 000 is the MSB
                    table_d[3'd7 - idx_q] = dut_out;
                    if (idx_q == 3'd7) begin
                        pass_d  = (table_d == exp_q);
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = SETTLE_RELOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // outputs are computed from the next state so the flops present them
        // in the same cycle the state register does
        busy_d = (state_d == SETTLE);
        done_d = (state_d == DONE);
        vec_d  = (state_d == SETTLE) ? idx_d : 3'b000;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            table_q <= 8'h00;
            exp_q   <= 8'h00;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vec_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vec_q   <= vec_d;
        end
    end

    assign {dut_in1, dut_in2, dut_in3} = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: four instances with different
// SETTLE_CYCLES share one behavioural gate (configurable function and delay);
// one instance sweeps at a time and a monitor checks each done pulse.
module tb_truth_table_sweeper;

    localparam int N_INST = 4;

    function automatic int s_of(input int i);
        case (i)
            0:       return 4;
            1:       return 0;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int         inst;
        logic [7:0] tbl;
        logic       pass;
        int         cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_INST-1:0] start;
    logic              abort;
    logic [7:0]        expected;
    logic [7:0]        gate_f = 8'h00;
    int                gate_d = 0;
    logic [N_INST-1:0] dut_out, busy, done, pass;
    logic [2:0]        vec [N_INST];
    logic [7:0]        tbl [N_INST];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        logic       d1, d2, d3;
        logic [2:0] pipe;

        truth_table_sweeper #(.SETTLE_CYCLES(s_of(g))) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start[g]),
            .abort     (abort),
            .expected  (expected),
            .dut_out   (dut_out[g]),
            .dut_in1   (d1),
            .dut_in2   (d2),
            .dut_in3   (d3),
            .busy      (busy[g]),
            .done      (done[g]),
            .table_out (tbl[g]),
            .pass      (pass[g])
        );

        assign vec[g] = {d1, d2, d3};
        // gate with gate_d cycles of output delay; pipe[k] is k+1 cycles old
        always @(posedge clk) pipe <= {pipe[1:0], gate_f[3'd7 - vec[g]]};
        assign dut_out[g] = (gate_d == 0) ? gate_f[3'd7 - vec[g]] : pipe[gate_d-1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: vector i is held for s+1 cycles starting at sweep cycle
    // i*(s+1) and sampled on its last cycle; a gate with delay d then shows
    // f() of whatever vector was driven d cycles earlier (000 before the sweep).
    function automatic logic [7:0] model_table(input int s, input logic [7:0] f, input int d);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int seen = i * (s + 1) + s - d;
            int v    = (seen < 0) ? 0 : seen / (s + 1);
            t[7-i] = f[7-v];
        end
        return t;
    endfunction

    // Monitor: every done pulse must match the oldest scoreboard entry.
    logic [N_INST-1:0] done_prev = '0;
    always @(negedge clk) begin
        for (int i = 0; i < N_INST; i++) begin
            if (done[i] === 1'b1) begin
                check("done_one_cycle", 32'(done_prev[i]), 32'(0));
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done[i]), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_inst", 32'(i), 32'(e.inst));
                    check("table_out", 32'(tbl[i]), 32'(e.tbl));
                    check("pass", 32'(pass[i]), 32'(e.pass));
                    check("done_latency", 32'(cyc), 32'(e.cyc));
                    check("busy_in_done", 32'(busy[i]), 32'(0));
                    check("vec_in_done", 32'(vec[i]), 32'(0));
                end
            end
        end
        done_prev = done;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start on one instance; returns #1 after the accepting edge.
    task automatic start_raw(input int inst, input logic [7:0] exp_v);
        @(negedge clk);
        start[inst] = 1'b1;
        expected    = exp_v;
        @(posedge clk);
        #1;
        start[inst] = 1'b0;
        expected    = 8'($urandom);
    endtask

    task automatic run_sweep(input int inst, input logic [7:0] f, input int d, input logic [7:0] exp_v);
        exp_t       e;
        logic [7:0] m;
        gate_f = f;
        gate_d = d;
        idle(4);
        m = model_table(s_of(inst), f, d);
        start_raw(inst, exp_v);
        e.inst = inst;
        e.tbl  = m;
        e.pass = (m == exp_v);
        e.cyc  = cyc + 8 * (s_of(inst) + 1);
        sb.push_back(e);
    endtask

    // Pulse start somewhere in SETTLE or DONE of the sweep just launched.
    task automatic poke_start(input int inst);
        int k;
        k = $urandom_range(8 * (s_of(inst) + 1) + 1, 1);
        repeat (k) @(negedge clk);
        start[inst] = 1'b1;
        @(posedge clk);
        #1;
        start[inst] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
    endtask

    task automatic wait_vec(input int inst, input logic [2:0] v);
        for (int i = 0; i < 200 && vec[inst] != v; i++) @(negedge clk);
        if (vec[inst] != v) check("wait_vec_timeout", 32'(vec[inst]), 32'(v));
    endtask

    task automatic check_idle_zero(input int inst, input string tag);
        check({tag, "_table"}, 32'(tbl[inst]), 32'(0));
        check({tag, "_pass"}, 32'(pass[inst]), 32'(0));
        check({tag, "_busy"}, 32'(busy[inst]), 32'(0));
        check({tag, "_done"}, 32'(done[inst]), 32'(0));
        check({tag, "_vec"}, 32'(vec[inst]), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = '0;
        abort    = 1'b0;
        expected = 8'h00;
        idle(3);
        for (int i = 0; i < N_INST; i++) check_idle_zero(i, "reset");
        reset = 1'b0;
        idle(2);

        // minterm-010 gate, matching and non-matching references
        run_sweep(0, 8'h20, 0, 8'h20);
        drain();
        run_sweep(0, 8'h20, 0, 8'h80);
        drain();

        // XOR3 with zero settle cycles
        run_sweep(1, 8'h69, 0, 8'h69);
        drain();

        // slow gate: too little settle fails, enough settle passes
        run_sweep(2, 8'h20, 3, 8'h20);
        drain();
        run_sweep(3, 8'h20, 3, 8'h20);
        drain();

        // abort held through IDLE is ignored and start wins when both are high
        abort = 1'b1;
        run_sweep(0, 8'h96, 0, 8'h96);
        abort = 1'b0;
        @(negedge clk);
        check("start_beats_abort_busy", 32'(busy[0]), 32'(1));
        drain();

        // second start while busy or in DONE is ignored
        run_sweep(0, 8'h5a, 1, 8'h5a);
        poke_start(0);
        drain();
        @(negedge clk);
        check("poke_not_queued_busy", 32'(busy[0]), 32'(0));

        // abort during vector 4 (instance 1 aborts on its sampling edge)
        for (int inst = 0; inst < 2; inst++) begin
            run_sweep(inst, 8'hff, 0, 8'hff);
            drain();
            start_raw(inst, 8'hff);
            wait_vec(inst, 3'd4);
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            @(negedge clk);
            check("abort_busy", 32'(busy[inst]), 32'(0));
            check("abort_done", 32'(done[inst]), 32'(0));
            check("abort_table", 32'(tbl[inst]), 32'(8'hf0));
            check("abort_pass", 32'(pass[inst]), 32'(0));
            check("abort_vec", 32'(vec[inst]), 32'(0));
            idle(3);
            check("abort_stays_idle", 32'(busy[inst]), 32'(0));
        end

        // reset during vector 5, then a normal sweep
        run_sweep(0, 8'hff, 0, 8'hff);
        drain();
        start_raw(0, 8'h3c);
        wait_vec(0, 3'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero(0, "midreset");
        idle(3);
        run_sweep(0, 8'hc3, 0, 8'hc3);
        drain();

        // randomized sweeps against the reference model
        for (int n = 0; n < 40; n++) begin
            int         inst;
            int         d;
            logic [7:0] f;
            logic [7:0] exp_v;
            inst  = $urandom_range(N_INST - 1, 0);
            d     = $urandom_range(3, 0);
            f     = 8'($urandom);
            exp_v = ($urandom_range(1, 0) == 1) ? model_table(s_of(inst), f, d) : 8'($urandom);
            run_sweep(inst, f, d, exp_v);
            if ($urandom_range(3, 0) == 0) poke_start(inst);
            drain();
        end

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, hold cycles per input vector before sampling, legal range 0..255.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one 8-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate a sweep in progress; no done pulse.
REQ-006 expected  input  8  expected truth table, latched on accepted start.
REQ-007 dut_out  input  1  output of the 3-input logic gate under test.
REQ-008 dut_in1, dut_in2, dut_in3  output  1 each  gate-under-test inputs; dut_in1 is MSB of the vector index.
REQ-009 busy  output  1  high while a sweep is in progress (state SETTLE).
REQ-010 done  output  1  single-cycle pulse when a sweep completes.
REQ-011 table_out  output  8  captured truth table; bit[7-i] = dut_out sampled for vector i.
REQ-012 pass  output  1  table_out == latched expected; valid from done until next accepted start.

Function
REQ-013 The block SHALL implement three states: IDLE, SETTLE and DONE.
REQ-014 IDLE: {dut_in1,dut_in2,dut_in3}=3'b000; busy=0; table_out and pass hold their last values.
REQ-015 IDLE with start=1 SHALL latch expected, clear table_out to 8'h00, clear pass, set idx=0 and counter=SETTLE_CYCLES, then enter SETTLE next cycle.
REQ-016 SETTLE: outputs {dut_in1,dut_in2,dut_in3}=idx[2:0]; busy=1; counter decrements by 1 each cycle while nonzero.
REQ-017 SETTLE with counter==0 SHALL write dut_out into table_out bit[7-idx] that cycle.
REQ-018 The sampling cycle with idx<7 SHALL increment idx and reload counter to SETTLE_CYCLES; remain in SETTLE.
REQ-019 The sampling cycle with idx==7 SHALL transition to DONE.
REQ-020 Each vector SHALL be held exactly SETTLE_CYCLES+1 cycles; vector order 000,001,...,111.
REQ-021 DONE: done=1 for exactly one cycle; pass=(final table_out == latched expected); busy=0; dut inputs 3'b000; next state IDLE.
REQ-022 Latency: start accepted at edge T, done high in cycle T+1+8*(SETTLE_CYCLES+1).
REQ-023 start while busy or in DONE SHALL be ignored; no queuing.
REQ-024 abort in SETTLE SHALL force IDLE next cycle; table_out keeps the partial contents; pass=0; done not asserted.
REQ-025 abort in IDLE or DONE SHALL have no effect; abort takes priority over sampling in the same cycle (that sample is discarded).
REQ-026 A start and abort asserted together in IDLE: start wins.
REQ-027 SETTLE_CYCLES=0: each vector is sampled in its first cycle; 8-cycle sweep.
REQ-028 The idx counter SHALL be 3 bits; the counter SHALL be 8 bits; no wrap beyond idx 7.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, idx=0, counter=0, table_out=8'h00, pass=0, done=0, busy=0, dut inputs 3'b000, latched expected=8'h00.
REQ-030 reset SHALL override start and abort and any state, including a sweep in progress, with no done pulse.

Verification
REQ-031 Gate model = minterm 010 only, expected=8'h20, SETTLE_CYCLES=4, start -> done at T+41, table_out=8'h20, pass=1.
REQ-032 Same gate, expected=8'h80 -> table_out=8'h20, pass=0, done pulses once.
REQ-033 SETTLE_CYCLES=0, gate=XOR3, expected=8'h69 -> done at T+9, table_out=8'h69, pass=1.
REQ-034 Model gate with 3-cycle output delay, SETTLE_CYCLES=1 -> table_out wrong, pass=0; SETTLE_CYCLES=3 -> pass=1.
REQ-035 abort during vector 4 -> IDLE next cycle, no done, busy=0, bits for vectors 0-3 retained, pass=0; second start while busy ignored.
REQ-036 reset mid-sweep (vector 5) -> all outputs at reset values next cycle; subsequent start completes a normal sweep.
